// File: rtl/truth_table_capture.sv
// rtl/truth_table_capture.sv - sweeps all input vectors of a combinational function and records its truth table
// Each vector is held SETTLE+1 cycles; f is sampled on the last of those edges.
module truth_table_capture #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic [2**N_IN-1:0]   expect_i,
  input  logic                 f_i,
  output logic [N_IN-1:0]      vec_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2**N_IN-1:0]   table_o,
  output logic [N_IN:0]        ones_o,
  output logic                 pass_o
);

  localparam int              W        = 2**N_IN;
  localparam logic [7:0]      SETTLE_C = 8'(SETTLE);
  localparam logic [N_IN-1:0] VEC_LAST = '1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [W-1:0]    table_q, table_d, table_wr;
  logic [W-1:0]    exp_q, exp_d;
  logic [N_IN:0]   ones_q, ones_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    table_d  = table_q;
    exp_d    = exp_q;
    ones_d   = ones_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    // The table as it will look once this edge's sample is written in.
    table_wr         = table_q;
    table_wr[vec_q]  = f_i;

    case (state_q)
      S_RUN: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          table_d = table_wr;
          ones_d  = ones_q + (N_IN+1)'(f_i);
          if (vec_q != VEC_LAST) begin
            vec_d = vec_q + 1'b1;
            cnt_d = SETTLE_C;
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (table_wr == exp_q);
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_IDLE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (start_i && (state_q != S_RUN)) begin
      vec_d   = '0;
      cnt_d   = SETTLE_C;
      table_d = '0;
      ones_d  = '0;
      pass_d  = 1'b0;
      exp_d   = expect_i;
      busy_d  = 1'b1;
      state_d = S_RUN;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      table_q <= '0;
      exp_q   <= '0;
      ones_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      table_q <= table_d;
      exp_q   <= exp_d;
      ones_q  <= ones_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign vec_o   = vec_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign table_o = table_q;
  assign ones_o  = ones_q;
  assign pass_o  = pass_q;

endmodule

// File: tb/tb_truth_table_capture.sv
// tb/tb_truth_table_capture.sv - scoreboard bench for truth_table_capture
// u_dut1 uses SETTLE=1 with s=(a&b)|(a&c); u_dut0 uses SETTLE=0 with a constant f.
module tb_truth_table_capture;

  typedef struct {
    logic [7:0] tbl;
    logic [3:0] ones;
    logic       pass;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start1 = 1'b0, start0 = 1'b0;
  logic [7:0] expect1 = 8'h00, expect0 = 8'h00;
  logic       f1_sel = 1'b1, f1_const = 1'b0, f0 = 1'b0;
  logic       f1;
  logic [2:0] vec1, vec0;
  logic       busy1, busy0, done1, done0, pass1, pass0;
  logic [7:0] table1, table0;
  logic [3:0] ones1, ones0;

  int   cyc = 0;
  int   s1 = 0;
  int   passed = 0;
  int   total = 0;
  exp_t q1[$];
  exp_t q0[$];
  logic prev_done1 = 1'b0, prev_done0 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign f1 = f1_sel ? ((vec1[2] & vec1[1]) | (vec1[2] & vec1[0])) : f1_const;

  truth_table_capture #(.N_IN(3), .SETTLE(1)) u_dut1 (
    .clk_i(clk), .reset_i(reset), .start_i(start1), .expect_i(expect1), .f_i(f1),
    .vec_o(vec1), .busy_o(busy1), .done_o(done1), .table_o(table1), .ones_o(ones1), .pass_o(pass1)
  );

  truth_table_capture #(.N_IN(3), .SETTLE(0)) u_dut0 (
    .clk_i(clk), .reset_i(reset), .start_i(start0), .expect_i(expect0), .f_i(f0),
    .vec_o(vec0), .busy_o(busy0), .done_o(done0), .table_o(table0), .ones_o(ones0), .pass_o(pass0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitors: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!reset && done1) begin
      check("dut1_done_one_cycle", {31'd0, prev_done1}, 32'd0);
      check("dut1_busy_at_done", {31'd0, busy1}, 32'd0);
      if (q1.size() == 0) begin
        check("dut1_unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        check("dut1_table", {24'd0, table1}, {24'd0, e.tbl});
        check("dut1_ones", {28'd0, ones1}, {28'd0, e.ones});
        check("dut1_pass", {31'd0, pass1}, {31'd0, e.pass});
        check("dut1_done_cycle", cyc, e.cyc);
      end
    end
    prev_done1 <= done1;
  end

  always @(negedge clk) begin
    if (!reset && done0) begin
      check("dut0_done_one_cycle", {31'd0, prev_done0}, 32'd0);
      if (q0.size() == 0) begin
        check("dut0_unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q0.pop_front();
        check("dut0_table", {24'd0, table0}, {24'd0, e.tbl});
        check("dut0_ones", {28'd0, ones0}, {28'd0, e.ones});
        check("dut0_pass", {31'd0, pass0}, {31'd0, e.pass});
        check("dut0_done_cycle", cyc, e.cyc);
      end
    end
    prev_done0 <= done0;
  end

  // Each vector of u_dut1 must be held exactly two cycles from the accepted start edge.
  always @(negedge clk) begin
    if (!reset && busy1) check("dut1_vec_seq", {29'd0, vec1}, (cyc - s1) / 2);
  end

  task automatic sweep1(input logic [7:0] ex, input logic [7:0] tbl, input logic [3:0] n, input logic p);
    exp_t e;
    @(negedge clk);
    expect1 = ex;
    start1  = 1'b1;
    s1      = cyc + 1;
    e.tbl = tbl; e.ones = n; e.pass = p; e.cyc = cyc + 1 + 16;
    q1.push_back(e);
    @(negedge clk);
    start1 = 1'b0;
  endtask

  task automatic sweep0(input logic fv, input logic [7:0] ex, input logic [7:0] tbl, input logic [3:0] n, input logic p);
    exp_t e;
    @(negedge clk);
    f0      = fv;
    expect0 = ex;
    start0  = 1'b1;
    e.tbl = tbl; e.ones = n; e.pass = p; e.cyc = cyc + 1 + 8;
    q0.push_back(e);
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q1.size() != 0 || q0.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", {31'd0, (q1.size() != 0 || q0.size() != 0)}, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int c;
    repeat (3) @(negedge clk);
    check("rst_vec", {29'd0, vec1}, 32'd0);
    check("rst_busy_done", {30'd0, busy1, done1}, 32'd0);
    check("rst_table_ones_pass", {19'd0, table1, ones1, pass1}, 32'd0);
    check("rst_dut0_table", {24'd0, table0}, 32'd0);
    reset = 1'b0;

    // Reset in mid-sweep: sweep is abandoned, no done follows.
    f1_sel = 1'b0; f1_const = 1'b1;
    @(negedge clk);
    expect1 = 8'hFF; start1 = 1'b1; s1 = cyc + 1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_table_nonzero", {31'd0, (table1 != 8'h00)}, 32'd1);
    reset = 1'b1;
    #1;
    check("midrst_vec", {29'd0, vec1}, 32'd0);
    check("midrst_busy_done", {30'd0, busy1, done1}, 32'd0);
    check("midrst_table_ones", {20'd0, table1, ones1}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("midrst_idle_busy", {31'd0, busy1}, 32'd0);

    f1_sel = 1'b1;
    sweep1(8'hE0, 8'hE0, 4'd3, 1'b1);
    drain();
    check("vec_holds_last", {29'd0, vec1}, 32'd7);
    sweep1(8'hE1, 8'hE0, 4'd3, 1'b0);
    drain();
    check("table_held_after_done", {24'd0, table1}, 32'hE0);

    // expect changes mid-sweep; the latched value decides pass.
    sweep1(8'hE0, 8'hE0, 4'd3, 1'b1);
    repeat (4) @(negedge clk);
    expect1 = 8'h00;
    drain();

    // start held high: ignored during RUN, restarts from the DONE cycle.
    begin
      exp_t e;
      @(negedge clk);
      c = cyc;
      expect1 = 8'hE0; start1 = 1'b1; s1 = c + 1;
      e.tbl = 8'hE0; e.ones = 4'd3; e.pass = 1'b1; e.cyc = c + 17;
      q1.push_back(e);
      e.cyc = c + 34;
      q1.push_back(e);
      repeat (17) @(negedge clk);
      s1 = c + 18;
      @(negedge clk);
      check("restart_busy", {31'd0, busy1}, 32'd1);
      check("restart_table_clear", {24'd0, table1}, 32'd0);
      check("restart_ones_clear", {28'd0, ones1}, 32'd0);
      start1 = 1'b0;
      drain();
      check("after_restart_idle", {31'd0, busy1}, 32'd0);
    end

    sweep0(1'b1, 8'hFF, 8'hFF, 4'd8, 1'b1);
    drain();
    sweep0(1'b0, 8'hFF, 8'h00, 4'd0, 1'b0);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
